// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions: FSM state encoding, register-file constants,
// the NOP instruction word and the encoded IF/ID / ID/EX control patterns.
package hazard_ctrl_pkg;

  // Mul/div tracking state
  typedef enum logic {
    HC_IDLE = 1'b0,
    HC_BUSY = 1'b1
  } hc_state_t;

  // Architectural zero register: never a real producer
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Instruction word used by the IF/ID register when it is flushed
  localparam int          INSTR_W   = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Width of the mul/div latency down-counter
  localparam int MD_CNT_W = 4;

  // Front-end control bundle driven by the hazard controller
  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_flush;
    logic id_ex_bubble;
  } hc_ctrl_t;

  localparam hc_ctrl_t CTRL_NORMAL = '{pc_write: 1'b1, if_id_write: 1'b1,
                                       if_flush: 1'b0, id_ex_bubble: 1'b0};
  localparam hc_ctrl_t CTRL_STALL  = '{pc_write: 1'b0, if_id_write: 1'b0,
                                       if_flush: 1'b0, id_ex_bubble: 1'b1};
  localparam hc_ctrl_t CTRL_FLUSH  = '{pc_write: 1'b1, if_id_write: 1'b1,
                                       if_flush: 1'b1, id_ex_bubble: 1'b1};

  // True when a non-zero destination register matches a source register
  function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] src);
    return (dst != REG_ZERO) && (dst == src);
  endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Parameterised-width saturating incrementer; holds at all-ones once reached.
module hc_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;
  logic         w_sat;

  assign w_sat = &r_cnt;

  // Count enabled cycles, stopping at the maximum representable value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_inc && !w_sat) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage integer pipeline: resolves
// load-use, mul/div-busy and taken-branch hazards in the same cycle and
// keeps a saturating count of stall cycles.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MD_LAT   = 4,
  parameter int STALL_CW = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4:0]          id_rs,
  input  logic [4:0]          id_rt,
  input  logic                id_uses_rt,
  input  logic                id_is_muldiv,
  input  logic                id_reads_hilo,
  input  logic                ex_mem_read,
  input  logic [4:0]          ex_rt,
  input  logic                ex_branch_taken,
  output logic                pc_write,
  output logic                if_id_write,
  output logic                if_flush,
  output logic                id_ex_bubble,
  output logic                md_busy,
  output logic [STALL_CW-1:0] stall_cnt
);

  // Counter reload value for a newly issued mul/div
  localparam logic [MD_CNT_W-1:0] MD_LOAD = MD_CNT_W'(MD_LAT);

  hc_state_t           r_state;
  hc_state_t           w_state_nxt;
  logic [MD_CNT_W-1:0] r_md_cnt;
  logic [MD_CNT_W-1:0] w_md_cnt_nxt;

  logic     w_md_busy;
  logic     w_lu_haz;
  logic     w_md_haz;
  logic     w_stall;
  logic     w_issue;
  hc_ctrl_t w_ctrl;

  // A result is pending for as long as the FSM sits in BUSY
  assign w_md_busy = (r_state == HC_BUSY);

  // Hazard detection; a taken branch squashes ID so it never stalls
  always_comb begin
    w_lu_haz = ex_mem_read &&
               (reg_match(ex_rt, id_rs) || (id_uses_rt && reg_match(ex_rt, id_rt)));
    w_md_haz = w_md_busy && (id_reads_hilo || id_is_muldiv);
    w_stall  = !ex_branch_taken && (w_lu_haz || w_md_haz);
    w_issue  = (r_state == HC_IDLE) && id_is_muldiv && !w_stall && !ex_branch_taken;
  end

  // Mul/div state and latency counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= HC_IDLE;
      r_md_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_md_cnt <= w_md_cnt_nxt;
    end
  end

  // Next state: load on issue, count down while busy, return to IDLE at zero
  always_comb begin
    w_state_nxt  = r_state;
    w_md_cnt_nxt = r_md_cnt;
    case (r_state)
      HC_IDLE: begin
        if (w_issue) begin
          w_state_nxt  = HC_BUSY;
          w_md_cnt_nxt = MD_LOAD;
        end
      end
      HC_BUSY: begin
        w_md_cnt_nxt = r_md_cnt - 1'b1;
        if (r_md_cnt <= MD_CNT_W'(1)) begin
          w_state_nxt = HC_IDLE;
        end
      end
      default: begin
        w_state_nxt  = HC_IDLE;
        w_md_cnt_nxt = '0;
      end
    endcase
  end

  // Front-end controls: flush beats stall beats normal; reset forces normal
  always_comb begin
    if (rst) begin
      w_ctrl = CTRL_NORMAL;
    end else if (ex_branch_taken) begin
      w_ctrl = CTRL_FLUSH;
    end else if (w_stall) begin
      w_ctrl = CTRL_STALL;
    end else begin
      w_ctrl = CTRL_NORMAL;
    end
  end

  assign pc_write     = w_ctrl.pc_write;
  assign if_id_write  = w_ctrl.if_id_write;
  assign if_flush     = w_ctrl.if_flush;
  assign id_ex_bubble = w_ctrl.id_ex_bubble;
  assign md_busy      = w_md_busy;

  // Performance counter of stall cycles (flush cycles excluded via w_stall)
  hc_sat_counter #(
    .W (STALL_CW)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_stall),
    .o_cnt (stall_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: directed scenarios plus randomized stimulus
// against a cycle-level behavioural model.
module tb_hazard_ctrl;

  localparam int MD_LAT   = 4;
  localparam int STALL_CW = 4;
  localparam int SAT_MAX  = 15;

  logic                clk = 1'b0;
  logic                rst;
  logic [4:0]          id_rs, id_rt, ex_rt;
  logic                id_uses_rt, id_is_muldiv, id_reads_hilo;
  logic                ex_mem_read, ex_branch_taken;
  logic                pc_write, if_id_write, if_flush, id_ex_bubble, md_busy;
  logic [STALL_CW-1:0] stall_cnt;
  logic [4:0]          obs;

  int checks = 0;
  int errors = 0;
  int m_rem  = 0;   // model: busy cycles still to run on the mul/div unit
  int m_cnt  = 0;   // model: stall cycles counted so far (saturating)

  hazard_ctrl #(
    .MD_LAT   (MD_LAT),
    .STALL_CW (STALL_CW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rt      (id_uses_rt),
    .id_is_muldiv    (id_is_muldiv),
    .id_reads_hilo   (id_reads_hilo),
    .ex_mem_read     (ex_mem_read),
    .ex_rt           (ex_rt),
    .ex_branch_taken (ex_branch_taken),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .if_flush        (if_flush),
    .id_ex_bubble    (id_ex_bubble),
    .md_busy         (md_busy),
    .stall_cnt       (stall_cnt)
  );

  always #5 clk = ~clk;

  // Observed controls packed as {pc_write, if_id_write, if_flush, id_ex_bubble, md_busy}
  assign obs = {pc_write, if_id_write, if_flush, id_ex_bubble, md_busy};

  function automatic logic model_stall();
    logic lu, md;
    if (rst) return 1'b0;
    lu = ex_mem_read && (ex_rt != 5'd0) &&
         ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    md = (m_rem > 0) && (id_reads_hilo || id_is_muldiv);
    return !ex_branch_taken && (lu || md);
  endfunction

  function automatic logic [4:0] model_ctrl();
    logic busy;
    busy = (m_rem > 0);
    if (rst)             return 5'b11000;
    if (ex_branch_taken) return {4'b1111, busy};
    if (model_stall())   return {4'b0001, busy};
    return {4'b1100, busy};
  endfunction

  // Advance one clock, updating the model from the inputs seen before the edge
  task automatic tick();
    logic st, iss;
    st  = model_stall();
    iss = !rst && (m_rem == 0) && id_is_muldiv && !st && !ex_branch_taken;
    @(posedge clk);
    if (rst) begin
      m_rem = 0;
      m_cnt = 0;
    end else begin
      if (m_rem > 0)  m_rem = m_rem - 1;
      else if (iss)   m_rem = MD_LAT;
      if (st && m_cnt < SAT_MAX) m_cnt = m_cnt + 1;
    end
    #1;
  endtask

  task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                        input logic mdv, input logic hl, input logic mr,
                        input logic [4:0] xrt, input logic br);
    id_rs = rs; id_rt = rt; id_uses_rt = urt; id_is_muldiv = mdv;
    id_reads_hilo = hl; ex_mem_read = mr; ex_rt = xrt; ex_branch_taken = br;
    #1;
  endtask

  task automatic idle_in();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_in();
    @(posedge clk);
    #1;
    rst   = 1'b0;
    m_rem = 0;
    m_cnt = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(5'd8, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0);
    checks++;
    if (obs !== 5'b11000) begin
      errors++; $display("FAIL reset_ctrl: got %b expected %b", obs, 5'b11000);
    end
    checks++;
    if (stall_cnt !== 4'd0) begin
      errors++; $display("FAIL reset_cnt: got %0d expected 0", stall_cnt);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_in();
  endtask

  task automatic test_load_use();
    do_reset();
    set_in(5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0);
    checks++;
    if (obs !== 5'b00010) begin
      errors++; $display("FAIL load_use_stall: got %b expected %b", obs, 5'b00010);
    end
    tick();
    idle_in();
    checks++;
    if (obs !== 5'b11000) begin
      errors++; $display("FAIL load_use_release: got %b expected %b", obs, 5'b11000);
    end
    checks++;
    if (stall_cnt !== 4'd1) begin
      errors++; $display("FAIL load_use_cnt: got %0d expected 1", stall_cnt);
    end
  endtask

  task automatic test_zero_reg();
    do_reset();
    set_in(5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0);
    checks++;
    if (obs !== 5'b11000) begin
      errors++; $display("FAIL zero_reg: got %b expected %b", obs, 5'b11000);
    end
    set_in(5'd3, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0);
    checks++;
    if (obs !== 5'b11000) begin
      errors++; $display("FAIL unused_rt: got %b expected %b", obs, 5'b11000);
    end
    set_in(5'd3, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0);
    checks++;
    if (obs !== 5'b00010) begin
      errors++; $display("FAIL used_rt: got %b expected %b", obs, 5'b00010);
    end
    tick();
    idle_in();
    checks++;
    if (stall_cnt !== 4'd1) begin
      errors++; $display("FAIL used_rt_cnt: got %0d expected 1", stall_cnt);
    end
  endtask

  task automatic test_muldiv();
    do_reset();
    set_in(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    checks++;
    if (obs !== 5'b11000) begin
      errors++; $display("FAIL mult_issue: got %b expected %b", obs, 5'b11000);
    end
    tick();
    for (int i = 1; i <= 5; i++) begin
      set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
      checks++;
      if (obs !== ((i <= 4) ? 5'b00011 : 5'b11000)) begin
        errors++; $display("FAIL mfhi_cycle%0d: got %b expected %b", i, obs,
                           (i <= 4) ? 5'b00011 : 5'b11000);
      end
      checks++;
      if (stall_cnt !== 4'(i - 1)) begin
        errors++; $display("FAIL mfhi_cnt%0d: got %0d expected %0d", i, stall_cnt, i - 1);
      end
      tick();
    end
    idle_in();
    checks++;
    if (stall_cnt !== 4'd4) begin
      errors++; $display("FAIL mfhi_total: got %0d expected 4", stall_cnt);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_in(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    tick();
    for (int i = 1; i <= 5; i++) begin
      checks++;
      if (obs !== ((i <= 4) ? 5'b00011 : 5'b11000)) begin
        errors++; $display("FAIL b2b_cycle%0d: got %b expected %b", i, obs,
                           (i <= 4) ? 5'b00011 : 5'b11000);
      end
      tick();
    end
    idle_in();
    checks++;
    if (obs !== 5'b11001) begin
      errors++; $display("FAIL b2b_second_busy: got %b expected %b", obs, 5'b11001);
    end
  endtask

  task automatic test_flush();
    do_reset();
    set_in(5'd8, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b1);
    checks++;
    if (obs !== 5'b11110) begin
      errors++; $display("FAIL flush_prio: got %b expected %b", obs, 5'b11110);
    end
    tick();
    idle_in();
    checks++;
    if (obs !== 5'b11000) begin
      errors++; $display("FAIL flush_no_issue: got %b expected %b", obs, 5'b11000);
    end
    checks++;
    if (stall_cnt !== 4'd0) begin
      errors++; $display("FAIL flush_cnt: got %0d expected 0", stall_cnt);
    end
    // Flush while a countdown is running must not disturb it
    set_in(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    tick();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1);
    checks++;
    if (obs !== 5'b11111) begin
      errors++; $display("FAIL flush_busy: got %b expected %b", obs, 5'b11111);
    end
    tick();
    idle_in();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs !== ((i < 3) ? 5'b11001 : 5'b11000)) begin
        errors++; $display("FAIL flush_countdown%0d: got %b expected %b", i, obs,
                           (i < 3) ? 5'b11001 : 5'b11000);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_in(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    tick();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    tick();
    tick();
    set_in(5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0);
    checks++;
    if (obs !== 5'b00011) begin
      errors++; $display("FAIL rstmid_pre: got %b expected %b", obs, 5'b00011);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (obs !== 5'b11000) begin
      errors++; $display("FAIL rstmid_ctrl: got %b expected %b", obs, 5'b11000);
    end
    checks++;
    if (stall_cnt !== 4'd0) begin
      errors++; $display("FAIL rstmid_cnt: got %0d expected 0", stall_cnt);
    end
    m_rem = 0;
    m_cnt = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    checks++;
    if (obs !== 5'b11000) begin
      errors++; $display("FAIL rstmid_hilo: got %b expected %b", obs, 5'b11000);
    end
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    set_in(5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0);
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (stall_cnt !== 4'((i < 15) ? i : 15)) begin
        errors++; $display("FAIL sat_cnt%0d: got %0d expected %0d", i, stall_cnt,
                           (i < 15) ? i : 15);
      end
      tick();
    end
    idle_in();
    checks++;
    if (stall_cnt !== 4'd15) begin
      errors++; $display("FAIL sat_final: got %0d expected 15", stall_cnt);
    end
  endtask

  task automatic test_random();
    logic [4:0] exp_ctrl;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1),
             5'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
      if (rst) begin
        m_rem = 0;
        m_cnt = 0;
      end
      exp_ctrl = model_ctrl();
      checks++;
      if (obs !== exp_ctrl) begin
        errors++; $display("FAIL rand_ctrl%0d: got %b expected %b", n, obs, exp_ctrl);
      end
      checks++;
      if (stall_cnt !== 4'(m_cnt)) begin
        errors++; $display("FAIL rand_cnt%0d: got %0d expected %0d", n, stall_cnt, m_cnt);
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_zero_reg();
    test_muldiv();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
